key_loader: RTL

KEY_LOADER -- requirements
Module: key_loader

---
 rtl/key_loader_pkg.sv | 16 +
 rtl/key_sipo.sv | 53 +++++
 rtl/key_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/key_loader_pkg.sv
// Shared types and default parameters for the serial key loader.
package key_loader_pkg;

  localparam int unsigned KEY_W_DEF     = 32;
  localparam int unsigned MAX_TRIES_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_ERROR   = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

endpackage

// File: rtl/key_sipo.sv
// Serial-in shadow register with bit counter and running even-parity check.
// Data bits land LSB first; the beat after the last data bit is the parity bit.
module key_sipo
  import key_loader_pkg::*;
#(
  parameter int unsigned KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             beat,
  input  logic             s_data,
  output logic [KEY_W-1:0] shadow,
  output logic             done,
  output logic             parity_ok
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_shadow;
  logic             r_done;
  logic             r_par_ok;

  // Shift data bits into place and fold every beat (data and parity) into the parity flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_done   <= 1'b0;
      r_par_ok <= 1'b1;
    end else if (clear) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_done   <= 1'b0;
      r_par_ok <= 1'b1;
    end else if (beat) begin
      r_par_ok <= r_par_ok ^ s_data;
      if (!r_done) begin
        for (int i = 0; i < int'(KEY_W); i++) begin
          if (r_cnt == CNT_W'(i)) r_shadow[i] <= s_data;
        end
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(KEY_W - 1)) r_done <= 1'b1;
      end
    end
  end

  assign shadow    = r_shadow;
  assign done      = r_done;
  assign parity_ok = r_par_ok;

endmodule

// File: rtl/key_loader.sv
// Serial key loader: receives a key plus even parity, publishes it only once
// verified, and locks itself out after MAX_TRIES parity failures.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int unsigned KEY_W     = KEY_W_DEF,
  parameter int unsigned MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic             lockout
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  state_t             r_state;
  logic [TRY_W-1:0]   r_tries;
  logic               r_s_ready;
  logic [KEY_W-1:0]   r_key_out;
  logic               r_key_valid;
  logic               r_busy;
  logic               r_err;
  logic               r_lockout;

  logic               w_beat;
  logic               w_start_ok;
  logic               w_fail;
  logic               w_clear;
  logic [TRY_W-1:0]   w_tries_inc;
  logic [KEY_W-1:0]   w_shadow;
  logic               w_done;
  logic               w_parity_ok;

  assign w_beat      = s_valid && r_s_ready;
  assign w_start_ok  = start && ((r_state == ST_IDLE) ||
                                 ((r_state == ST_ERROR) && (r_tries < TRY_W'(MAX_TRIES))));
  assign w_fail      = (r_state == ST_CHECK) && !w_parity_ok;
  // Shadow is wiped both at the start of a load and after a failed check
  assign w_clear     = w_start_ok || w_fail;
  assign w_tries_inc = (r_tries == TRY_W'(MAX_TRIES)) ? r_tries : r_tries + TRY_W'(1);

  key_sipo #(
    .KEY_W (KEY_W)
  ) u_sipo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (w_clear),
    .beat      (w_beat),
    .s_data    (s_data),
    .shadow    (w_shadow),
    .done      (w_done),
    .parity_ok (w_parity_ok)
  );

  // Load-control FSM with registered outputs updated on each transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_tries     <= '0;
      r_s_ready   <= 1'b0;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_lockout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (w_start_ok) begin
            r_state   <= ST_SHIFT;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (w_beat && w_done) begin
            r_state   <= ST_CHECK;
            r_s_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_busy <= 1'b0;
          if (w_parity_ok) begin
            r_state     <= ST_ACTIVE;
            r_key_out   <= w_shadow;
            r_key_valid <= 1'b1;
          end else begin
            r_tries <= w_tries_inc;
            r_err   <= 1'b1;
            if (w_tries_inc == TRY_W'(MAX_TRIES)) begin
              r_state   <= ST_LOCKOUT;
              r_lockout <= 1'b1;
            end else begin
              r_state <= ST_ERROR;
            end
          end
        end
        ST_ACTIVE, ST_LOCKOUT: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign key_out   = r_key_out;
  assign key_valid = r_key_valid;
  assign busy      = r_busy;
  assign err       = r_err;
  assign lockout   = r_lockout;

endmodule
